spike_pulse_decoder: RTL and testbench
======================================

Name: spike_pulse_decoder

Overview:
Receive-side counterpart of the single-cycle-to-wide spike pulse converter. It accepts spike pulses that are 2^WRES cycles wide and emits one single-cycle spike per pulse. It timestamps each spike's arrival relative to the last gamma (frame) start, and flags truncated pulses. It sits at the input of a neuron column, between an upstream layer's wide spike outputs and single-cycle temporal-coding logic.

Parameters:
WRES, 3, weight bit resolution; expected pulse width W = 2^WRES cycles.
TRES, 4, arrival-time bit resolution; time code saturates at 2^TRES-1.

Ports:
clk  input  1  unit clock for temporal encoding
rst  input  1  asynchronous, active-high reset
in  input  1  wide spike pulse, nominally W cycles high
gamma  input  1  single-cycle frame-start strobe
out  output  1  single-cycle spike, one per decoded pulse
t_arr  output  TRES  arrival time of the latest spike; valid when out=1, held until the next spike
err_short  output  1  single-cycle flag: pulse ended with fewer than W high cycles

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - Asserting rst immediately forces out=0, err_short=0, t_arr=0, cnt=0, state=WAIT_LOW, and tcnt to all ones.
  - Reset mid-pulse abandons that pulse with no out and no err_short.
- All outputs are registered; there is no combinational path from in to any output.
- Time counter tcnt (TRES bits):
  - gamma=1 -> tcnt<=1.
  - Otherwise tcnt<=tcnt+1, saturating at 2^TRES-1.
  - The current time tnow is 0 when gamma=1, else tcnt. Gamma at cycle 0 therefore gives tnow=k at cycle k.
- Pulse counter cnt is WRES+1 bits, range 0..W.
- State machine, evaluated on each posedge clk:
  - WAIT_LOW (reset state): in=0 -> IDLE. in=1 -> stay. A pulse already in progress when reset is released is ignored.
  - IDLE: in=1 -> onset.
  - BUSY, in=1, cnt<W: cnt<=cnt+1.
  - BUSY, in=1, cnt==W: back-to-back pulse from the encoder. Treat as a new onset.
  - BUSY, in=0, cnt==W: clean end, go to IDLE. No flag.
  - BUSY, in=0, cnt<W: err_short<=1 for one cycle, go to IDLE. No out retraction.
  - Onset action: out<=1 for one cycle, t_arr<=tnow, cnt<=1, state<=BUSY.
- Latency:
  - out and t_arr update one cycle after the first high cycle of a pulse.
  - err_short asserts one cycle after the first low cycle of a short pulse.
- Pulse lengths:
  - A pulse of n*W contiguous cycles yields n spikes, spaced W cycles apart.
  - A pulse of n*W+r cycles (0<r<W) yields n+1 spikes plus one err_short.
  - A one-cycle pulse yields out and then err_short on consecutive cycles.
- Gamma has no effect on the pulse FSM. A gamma in the same cycle as an onset gives t_arr=0.
- out and err_short are never high in the same cycle, because an onset requires in=1 and err_short requires in=0.

Test Plan:
- WRES=3, TRES=4. gamma at cycle 0; in high cycles 3..10 -> out=1 only in cycle 4, t_arr=3 from cycle 4 on, err_short never asserted.
- gamma at cycle 0; in high cycles 3..7 (5 cycles) -> out=1 in cycle 4 with t_arr=3, err_short=1 only in cycle 9.
- gamma at cycle 0; in high cycles 2..17 (16 cycles) -> out=1 in cycles 3 and 11, t_arr=2 then 10, no err_short.
- Timestamp boundaries:
  - gamma and in rising together in cycle 5 -> t_arr=0 in cycle 6.
  - gamma at cycle 0, next spike onset at cycle 20 -> t_arr=15 (saturated).
  - No gamma since reset -> t_arr=15.
- Reset boundaries:
  - rst pulsed asynchronously mid-pulse -> out, err_short, t_arr go to 0 before the next clock edge.
  - After release with in still high for 4 cycles -> no out and no err_short.
  - After in falls, next rising edge -> normal out.
- in high for exactly 1 cycle (cycle 3) -> out in cycle 4, err_short in cycle 5. A new 8-cycle pulse starting in cycle 5 -> out in cycle 6, no error.

Source files
------------

// File: rtl/spike_pulse_if.sv
// Bundle between an upstream wide-spike source and the spike pulse decoder.
// The master drives the wide pulse and frame strobe. The slave returns the decoded spike, its timestamp and the short-pulse flag.
interface spike_pulse_if #(
  parameter int TRES = 4
);
  logic            in;
  logic            gamma;
  logic            out;
  logic [TRES-1:0] t_arr;
  logic            err_short;

  modport master (
    output in, gamma,
    input  out, t_arr, err_short
  );

  modport slave (
    input  in, gamma,
    output out, t_arr, err_short
  );
endinterface

// File: rtl/spike_pulse_decoder.sv
// Converts 2^WRES-cycle-wide spike pulses into single-cycle spikes.
// Each spike is timestamped against the last gamma strobe, and truncated pulses are flagged.
module spike_pulse_decoder #(
  parameter int WRES = 3,
  parameter int TRES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  spike_pulse_if.slave         bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    BUSY     = 2'd2
  } state_e;

  localparam logic [WRES:0]   W_CNT = {1'b1, {WRES{1'b0}}};
  localparam logic [TRES-1:0] T_MAX = {TRES{1'b1}};

  state_e          state_q;
  logic [WRES:0]   cnt_q;
  logic [TRES-1:0] tcnt_q;
  logic [TRES-1:0] t_arr_q;
  logic            out_q;
  logic            err_q;
  logic [TRES-1:0] tnow;

  // A gamma in the onset cycle stamps the spike at time zero.
  assign tnow = bus.gamma ? '0 : tcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOW;
      cnt_q   <= '0;
      tcnt_q  <= T_MAX;
      t_arr_q <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (bus.gamma) begin
        tcnt_q <= {{(TRES-1){1'b0}}, 1'b1};
      end else if (tcnt_q != T_MAX) begin
        tcnt_q <= tcnt_q + 1'b1;
      end

      out_q <= 1'b0;
      err_q <= 1'b0;

      case (state_q)
        WAIT_LOW: begin
          // A pulse already in flight at reset release is never decoded.
          if (!bus.in) state_q <= IDLE;
        end
        IDLE: begin
          if (bus.in) begin
            out_q   <= 1'b1;
            t_arr_q <= tnow;
            cnt_q   <= {{WRES{1'b0}}, 1'b1};
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.in) begin
            if (cnt_q == W_CNT) begin
              // A full-width pulse runs straight into the next one from the encoder.
              out_q   <= 1'b1;
              t_arr_q <= tnow;
              cnt_q   <= {{WRES{1'b0}}, 1'b1};
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            err_q   <= (cnt_q != W_CNT);
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= WAIT_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.t_arr     = t_arr_q;
  assign bus.err_short = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_spike_pulse_decoder.sv
// Directed bench for spike_pulse_decoder with WRES=3 and TRES=4.
// Scenario table: cycle k's inputs are applied, then the outputs of cycle k+1 are compared.
module tb_spike_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  spike_pulse_if #(.TRES(4)) bus ();

  spike_pulse_decoder #(.WRES(3), .TRES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int g_cyc;            // gamma cycle, -1 = none
    int s1; int l1;       // first pulse start/length
    int s2; int l2;       // second pulse start/length, s2 = -1 for none
    int o1; int t1;       // first expected out cycle and t_arr
    int o2; int t2;       // second expected out cycle and t_arr, o2 = -1 for none
    int e;                // expected err_short cycle, -1 for none
    int ncyc;
  } vec_t;

  vec_t tbl[7];

  task automatic step(input logic i, input logic g);
    bus.in    = i;
    bus.gamma = g;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int cyc,
                       input logic eo, input logic ee, input logic [3:0] et);
    checks++;
    if (bus.out !== eo || bus.err_short !== ee || bus.t_arr !== et) begin
      errors++;
      $display("FAIL %s cyc %0d: out/err/t_arr got %b/%b/%0d expected %b/%b/%0d",
               name, cyc, bus.out, bus.err_short, bus.t_arr, eo, ee, et);
    end
  endtask

  task automatic do_reset();
    bus.in    = 1'b0;
    bus.gamma = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    check("reset_outputs", -1, 1'b0, 1'b0, 4'd0);
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got %0d expected 0", state_dbg);
    end
    rst = 1'b0;
    step(1'b0, 1'b0);  // leaves WAIT_LOW
  endtask

  initial begin
    logic       in_k;
    logic [3:0] exp_t;
    string      nm;

    tbl[0] = '{0,  3, 8,  -1, 0,  4, 3,  -1, 0,   -1, 16};  // exact-width pulse
    tbl[1] = '{0,  3, 5,  -1, 0,  4, 3,  -1, 0,    9, 12};  // 5-cycle short pulse
    tbl[2] = '{0,  2, 16, -1, 0,  3, 2,  11, 10,  -1, 20};  // back-to-back pair
    tbl[3] = '{5,  5, 8,  -1, 0,  6, 0,  -1, 0,   -1, 16};  // gamma with onset
    tbl[4] = '{0, 20, 8,  -1, 0, 21, 15, -1, 0,   -1, 30};  // saturated timestamp
    tbl[5] = '{-1, 4, 8,  -1, 0,  5, 15, -1, 0,   -1, 16};  // no gamma since reset
    tbl[6] = '{0,  3, 1,   5, 8,  4, 3,   6, 5,    5, 16};  // 1-cycle pulse then full

    for (int r = 0; r < 7; r++) begin
      do_reset();
      exp_t = 4'd0;
      nm = $sformatf("row%0d", r);
      for (int k = 0; k < tbl[r].ncyc; k++) begin
        in_k = (k >= tbl[r].s1 && k < tbl[r].s1 + tbl[r].l1) ||
               (tbl[r].s2 >= 0 && k >= tbl[r].s2 && k < tbl[r].s2 + tbl[r].l2);
        step(in_k, k == tbl[r].g_cyc);
        if (k + 1 == tbl[r].o1) exp_t = 4'(tbl[r].t1);
        if (k + 1 == tbl[r].o2) exp_t = 4'(tbl[r].t2);
        check(nm, k + 1,
              (k + 1 == tbl[r].o1) || (k + 1 == tbl[r].o2),
              (k + 1 == tbl[r].e), exp_t);
      end
    end

    // Asynchronous reset mid-pulse, then a pulse still high after release.
    do_reset();
    step(1'b1, 1'b0);
    check("mid_onset", 1, 1'b1, 1'b0, 4'd15);
    #2 rst = 1'b1;
    #1 check("async_rst", 1, 1'b0, 1'b0, 4'd0);
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0);
      check("held_after_rst", k, 1'b0, 1'b0, 4'd0);
    end
    step(1'b0, 1'b0);
    check("fall_after_rst", 0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0);
    check("rise_after_rst", 0, 1'b1, 1'b0, 4'd15);
    step(1'b1, 1'b0);
    check("rise_after_rst_next", 1, 1'b0, 1'b0, 4'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
